// File: rtl/sysinfo_pkg.sv
// sysinfo_pkg: register indices, field layout and response codes for sysinfo_axi.
// Revision: 1.0
`default_nettype none

package sysinfo_pkg;

  typedef enum logic [2:0] {
    IDX_VER       = 3'd0,
    IDX_BOARD     = 3'd1,
    IDX_TIMESTAMP = 3'd2,
    IDX_GITHASH   = 3'd3,
    IDX_SCRATCH   = 3'd4,
    IDX_UPTIME_LO = 3'd5,
    IDX_UPTIME_HI = 3'd6,
    IDX_CTRL      = 3'd7
  } reg_idx_e;

  localparam int REG_IDX_LSB   = 2;
  localparam int REG_IDX_MSB   = 4;
  localparam int VER_MAJ_W     = 8;
  localparam int VER_MIN_W     = 8;
  localparam int VER_BUILD_W   = 16;
  localparam int BOARD_FIELD_W = 16;
  localparam int CTRL_CLR_BIT  = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sysinfo_sync.sv
// sysinfo_sync: multi-flop synchroniser for a quasi-static input bus.
// Revision: 1.0
`default_nettype none

module sysinfo_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES*WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
  end

  assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/sysinfo_axi.sv
// sysinfo_axi: AXI4-lite read-mostly system information block with uptime counter.
// Revision: 1.0
`default_nettype none

module sysinfo_axi
  import sysinfo_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [7:0]  C_VER_MAJ          = 8'd0,
  parameter logic [7:0]  C_VER_MIN          = 8'd1,
  parameter logic [15:0] C_VER_BUILD        = 16'd0,
  parameter logic [31:0] C_BUILD_TIMESTAMP  = 32'd0,
  parameter logic [31:0] C_GIT_HASH         = 32'd0,
  parameter int          C_BOARD_TYPE_WIDTH = 4,
  parameter int          C_BOARD_REV_WIDTH  = 4,
  parameter int          C_SYNC_STAGES      = 2
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [C_BOARD_TYPE_WIDTH-1:0]   board_type,
  input  logic [C_BOARD_REV_WIDTH-1:0]    board_rev
);

  logic [C_BOARD_TYPE_WIDTH-1:0] board_type_s;
  logic [C_BOARD_REV_WIDTH-1:0]  board_rev_s;
  logic [63:0]                   uptime;
  logic [31:0]                   uptime_hi_snap;
  logic [31:0]                   scratch;
  logic                          aw_done;
  logic                          w_done;
  reg_idx_e                      wr_idx;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;
  logic                          commit;
  logic                          ctrl_clear;
  logic [1:0]                    wr_resp;
  reg_idx_e                      rd_idx;
  logic                          rd_hs;
  logic [31:0]                   rd_data;
  logic [1:0]                    rd_resp;
  logic                          unused_ok;

  sysinfo_sync #(.WIDTH(C_BOARD_TYPE_WIDTH), .STAGES(C_SYNC_STAGES)) u_sync_type (
    .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(board_type), .q(board_type_s)
  );

  sysinfo_sync #(.WIDTH(C_BOARD_REV_WIDTH), .STAGES(C_SYNC_STAGES)) u_sync_rev (
    .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(board_rev), .q(board_rev_s)
  );

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  // ---------------- write path ----------------
  assign commit     = aw_done && w_done && !s_axi_bvalid;
  assign ctrl_clear = commit && (wr_idx == IDX_CTRL) && wr_strb[CTRL_CLR_BIT] && wr_data[CTRL_CLR_BIT];
  assign wr_resp    = (wr_idx == IDX_SCRATCH || wr_idx == IDX_CTRL) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wr_idx        <= IDX_VER;
      wr_data       <= '0;
      wr_strb       <= '0;
      scratch       <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid && !s_axi_awready && !aw_done && !s_axi_bvalid;
      s_axi_wready  <= s_axi_wvalid && !s_axi_wready && !w_done && !s_axi_bvalid;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_done <= 1'b1;
        wr_idx  <= reg_idx_e'(s_axi_awaddr[REG_IDX_MSB:REG_IDX_LSB]);
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_done  <= 1'b1;
        wr_data <= s_axi_wdata;
        wr_strb <= s_axi_wstrb;
      end
      if (commit) begin
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
        if (wr_idx == IDX_SCRATCH) scratch <= merge_bytes(scratch, wr_data, wr_strb);
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // A same-cycle LO read samples the register before this edge, i.e. pre-clear.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  uptime <= '0;
    else if (ctrl_clear) uptime <= '0;
    else                 uptime <= uptime + 64'd1;
  end

  // ---------------- read path ----------------
  assign rd_idx = reg_idx_e'(s_axi_araddr[REG_IDX_MSB:REG_IDX_LSB]);
  assign rd_hs  = s_axi_arvalid && s_axi_arready;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IDX_VER:       rd_data = {C_VER_MAJ, C_VER_MIN, C_VER_BUILD};
      IDX_BOARD:     rd_data = {BOARD_FIELD_W'(board_type_s), BOARD_FIELD_W'(board_rev_s)};
      IDX_TIMESTAMP: rd_data = C_BUILD_TIMESTAMP;
      IDX_GITHASH:   rd_data = C_GIT_HASH;
      IDX_SCRATCH:   rd_data = scratch;
      IDX_UPTIME_LO: rd_data = uptime[31:0];
      IDX_UPTIME_HI: rd_data = uptime_hi_snap;
      default:       rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_arready  <= 1'b0;
      s_axi_rvalid   <= 1'b0;
      s_axi_rdata    <= '0;
      s_axi_rresp    <= RESP_OKAY;
      uptime_hi_snap <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
        if (rd_idx == IDX_UPTIME_LO) uptime_hi_snap <= uptime[63:32];
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
